// File: rtl/data_ram_ws_pkg.sv
// data_ram_ws_pkg: shared state encoding and lane width for the wait-state data RAM
package data_ram_ws_pkg;
  typedef enum logic [1:0] {
    DRW_IDLE = 2'd0,
    DRW_WAIT = 2'd1,
    DRW_RESP = 2'd2
  } drw_state_e;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/data_ram_ws_byte_lane_ram.sv
// byte_lane_ram: one byte lane of the data array, registered read-first output, no reset
module byte_lane_ram
  import data_ram_ws_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_ram_ws.sv
// data_ram_ws: byte-lane data memory with valid/ready request, programmable wait states
// and a one-cycle registered response with lane-masked read data and error flag
module data_ram_ws
  import data_ram_ws_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES-1:0]        req_sel,
  input  logic [BYTE_W*LANES-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [BYTE_W*LANES-1:0] resp_rdata,
  output logic                    resp_err,
  output logic                    busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  drw_state_e state, state_nx;
  logic [3:0] cnt;
  logic idle, accept, access;
  logic lat_we, lat_oor, req_oor, acc_we, acc_oor, acc_err, err_q;
  logic [AW-1:0] lat_word, last_word, acc_word, ram_addr;
  logic [LANES-1:0] lat_sel, acc_sel, rd_mask;
  logic [BYTE_W*LANES-1:0] lat_wdata, acc_wdata, lane_q;
  logic addr_unused;
  assign addr_unused = ^req_addr[1:0];
  assign idle = state == DRW_IDLE;
  assign accept = idle && req_valid;
  assign req_oor = req_addr[ADDR_W-1:AW+2] != '0;
  // With zero wait states the access happens on the accept edge, straight from the request port
  assign acc_we = idle ? req_we : lat_we;
  assign acc_oor = idle ? req_oor : lat_oor;
  assign acc_word = idle ? req_addr[AW+1:2] : lat_word;
  assign acc_sel = idle ? req_sel : lat_sel;
  assign acc_wdata = idle ? req_wdata : lat_wdata;
  assign acc_err = acc_oor || acc_sel == '0;
  // Between accesses the lanes keep re-reading the last word so their output stays put
  assign ram_addr = access ? acc_word : last_word;
  assign req_ready = idle;
  assign busy = !idle;
  assign resp_valid = state == DRW_RESP;
  assign resp_err = err_q;
  always_comb begin
    state_nx = state;
    access = 1'b0;
    case (state)
      DRW_IDLE: begin
        state_nx = accept ? (WAIT_CYCLES == 0 ? DRW_RESP : DRW_WAIT) : DRW_IDLE;
        access = accept && WAIT_CYCLES == 0;
      end
      DRW_WAIT: begin
        state_nx = cnt == 4'd1 ? DRW_RESP : DRW_WAIT;
        access = cnt == 4'd1;
      end
      DRW_RESP: state_nx = DRW_IDLE;
      default:  state_nx = DRW_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DRW_IDLE;
      cnt <= '0;
      lat_we <= 1'b0;
      lat_oor <= 1'b0;
      lat_word <= '0;
      lat_sel <= '0;
      lat_wdata <= '0;
      last_word <= '0;
      rd_mask <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
        lat_we <= req_we;
        lat_oor <= req_oor;
        lat_word <= req_addr[AW+1:2];
        lat_sel <= req_sel;
        lat_wdata <= req_wdata;
      end else if (state == DRW_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        last_word <= acc_word;
        rd_mask <= (acc_we || acc_err) ? '0 : acc_sel;
        err_q <= acc_err;
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    byte_lane_ram #(.DEPTH(DEPTH_WORDS)) u_lane (
      .clk   (clk),
      .we    (access && acc_we && !acc_err && acc_sel[i]),
      .addr  (ram_addr),
      .wdata (acc_wdata[BYTE_W*i +: BYTE_W]),
      .rdata (lane_q[BYTE_W*i +: BYTE_W])
    );
    assign resp_rdata[BYTE_W*i +: BYTE_W] = rd_mask[i] ? lane_q[BYTE_W*i +: BYTE_W] : '0;
  end
endmodule

// File: tb/tb_data_ram_ws.sv
// tb_data_ram_ws: directed and randomized checks of data_ram_ws with 2 and 0 wait states
module tb_data_ram_ws;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rv [2], rr [2], wev [2], rvld [2], err [2], bsy [2];
  logic [31:0] ad [2], wdt [2], rdat [2];
  logic [3:0] sl [2];
  logic [31:0] mdl [2][256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_ram_ws #(.LANES(4), .DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[g]), .req_ready(rr[g]), .req_we(wev[g]),
      .req_addr(ad[g]), .req_sel(sl[g]), .req_wdata(wdt[g]), .resp_valid(rvld[g]),
      .resp_rdata(rdat[g]), .resp_err(err[g]), .busy(bsy[g])
    );
  end

  function automatic int wlat(input int d);
    return d == 0 ? 3 : 1;
  endfunction

  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output logic one);
    int n;
    @(posedge clk); #1;
    rv[d] = 1'b1; wev[d] = w; ad[d] = a; sl[d] = s; wdt[d] = wd;
    n = 0;
    @(negedge clk);
    while (!rr[d] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rv[d] = 1'b0;
    lat = -1; rd = 'x; er = 1'bx; one = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rvld[d]) begin
        lat = c; rd = rdat[d]; er = err[d];
        @(negedge clk);
        one = !rvld[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < 2; d++) begin
        checks++; if (rr[d] !== 1'b1) begin errors++; $display("FAIL reset_ready d%0d: got %b want 1", d, rr[d]); end
        checks++; if (bsy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d: got %b want 0", d, bsy[d]); end
        checks++; if (rvld[d] !== 1'b0) begin errors++; $display("FAIL reset_valid d%0d: got %b want 0", d, rvld[d]); end
        checks++; if (rdat[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata d%0d: got %h want 0", d, rdat[d]); end
        checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err d%0d: got %b want 0", d, err[d]); end
      end
      if (p == 0) begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
      end
    end
  endtask

  task automatic test_rw();
    logic [31:0] rd; logic er, one; int lat;
    for (int d = 0; d < 2; d++) begin
      xact(d, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat, one);
      checks++; if (lat !== wlat(d)) begin errors++; $display("FAIL wr_latency d%0d: got %0d want %0d", d, lat, wlat(d)); end
      checks++; if (one !== 1'b1) begin errors++; $display("FAIL wr_pulse d%0d: got %b want 1", d, one); end
      checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL wr_resp d%0d: got err=%b rdata=%h want 0/0", d, er, rd); end
      xact(d, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, one);
      checks++; if (lat !== wlat(d)) begin errors++; $display("FAIL rd_latency d%0d: got %0d want %0d", d, lat, wlat(d)); end
      checks++; if (one !== 1'b1) begin errors++; $display("FAIL rd_pulse d%0d: got %b want 1", d, one); end
      checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_data d%0d: got err=%b rdata=%h want 0/deadbeef", d, er, rd); end
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic er, one; int lat;
    for (int d = 0; d < 2; d++) begin
      xact(d, 1'b1, 32'h10, 4'b0101, 32'h11223344, rd, er, lat, one);
      xact(d, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, one);
      checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL lane_merge d%0d: got %h want de22be44", d, rd); end
      xact(d, 1'b0, 32'h11, 4'b0011, 32'h0, rd, er, lat, one);
      checks++; if (rd !== 32'h0000BE44) begin errors++; $display("FAIL lane_mask d%0d: got %h want 0000be44", d, rd); end
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er, one; int lat;
    xact(0, 1'b1, 32'h0, 4'hF, 32'hA5A55A5A, rd, er, lat, one);
    xact(0, 1'b0, 32'h3FC, 4'hF, 32'h0, rd, er, lat, one);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL top_word_err: got %b want 0", er); end
    xact(0, 1'b0, 32'h400, 4'hF, 32'h0, rd, er, lat, one);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_read: got err=%b rdata=%h want 1/0", er, rd); end
    xact(0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, rd, er, lat, one);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b want 1", er); end
    xact(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat, one);
    checks++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL no_wrap: got %h want a5a55a5a", rd); end
    xact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat, one);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL sel0: got err=%b rdata=%h want 1/0", er, rd); end
  endtask

  task automatic test_held();
    int resps [$];
    int acc = 0;
    logic exp_rdy, acc_now;
    logic [31:0] rd2 = 'x;
    @(posedge clk); #1;
    rv[0] = 1'b1; wev[0] = 1'b1; ad[0] = 32'h40; sl[0] = 4'hF; wdt[0] = 32'h0BADF00D;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rvld[0]) begin resps.push_back(c); if (resps.size() == 2) rd2 = rdat[0]; end
      exp_rdy = c == 0 || c == 4 || c >= 8;
      checks++; if (rr[0] !== exp_rdy) begin errors++; $display("FAIL held_ready c%0d: got %b want %b", c, rr[0], exp_rdy); end
      acc_now = rv[0] && rr[0];
      @(posedge clk); #1;
      if (acc_now) begin
        acc++;
        if (acc == 1) wev[0] = 1'b0; else rv[0] = 1'b0;
      end
    end
    rv[0] = 1'b0;
    checks++; if (resps.size() !== 2) begin errors++; $display("FAIL held_count: got %0d want 2", resps.size()); end
    else begin
      checks++; if (resps[0] !== 3 || resps[1] !== 7) begin errors++; $display("FAIL held_timing: got %0d,%0d want 3,7", resps[0], resps[1]); end
    end
    checks++; if (rd2 !== 32'h0BADF00D) begin errors++; $display("FAIL held_data: got %h want 0badf00d", rd2); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er, one; int lat, seen;
    xact(0, 1'b1, 32'h20, 4'hF, 32'h12345678, rd, er, lat, one);
    @(posedge clk); #1;
    rv[0] = 1'b1; wev[0] = 1'b1; ad[0] = 32'h20; sl[0] = 4'hF; wdt[0] = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++; if ({rr[0], bsy[0]} !== 2'b10) begin errors++; $display("FAIL wait_reset_state: got ready/busy=%b want 10", {rr[0], bsy[0]}); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rvld[0]) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL wait_reset_resp: got %0d responses want 0", seen); end
    xact(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat, one);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wait_reset_array: got %h want 12345678", rd); end
    xact(1, 1'b1, 32'h20, 4'hF, 32'h12345678, rd, er, lat, one);
    @(posedge clk); #1;
    rv[1] = 1'b1; wev[1] = 1'b1; ad[1] = 32'h20; sl[1] = 4'hF; wdt[1] = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(negedge clk);
    checks++; if (rvld[1] !== 1'b1) begin errors++; $display("FAIL w0_latency: got valid=%b want 1", rvld[1]); end
    rst_n = 1'b0;
    #1;
    checks++; if (rvld[1] !== 1'b0) begin errors++; $display("FAIL resp_reset_valid: got %b want 0", rvld[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    xact(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat, one);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL resp_reset_array: got %h want cafef00d", rd); end
  endtask

  task automatic test_random();
    int pool [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 254, 255};
    logic [31:0] rd, a, wd, exp_rd; logic er, one, w, exp_err; logic [3:0] s; int lat, k, word;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        wd = $urandom;
        xact(d, 1'b1, 32'(pool[i] * 4), 4'hF, wd, rd, er, lat, one);
        mdl[d][pool[i]] = wd;
      end
      for (int n = 0; n < 30; n++) begin
        k = $urandom_range(0, 11);
        a = k < 10 ? 32'(pool[k] * 4 + $urandom_range(0, 3)) : (k == 10 ? 32'h400 + 32'($urandom_range(0, 255)) : 32'hFFFFFFFC);
        s = 4'($urandom_range(0, 15));
        w = 1'($urandom_range(0, 1));
        wd = $urandom;
        exp_err = a >= 32'd1024 || s == 4'd0;
        exp_rd = 32'h0;
        if (!exp_err) begin
          word = int'(a / 4);
          for (int b = 0; b < 4; b++) begin
            if (s[b] && w) mdl[d][word][8*b +: 8] = wd[8*b +: 8];
            if (s[b] && !w) exp_rd[8*b +: 8] = mdl[d][word][8*b +: 8];
          end
        end
        xact(d, w, a, s, wd, rd, er, lat, one);
        checks++; if (lat !== wlat(d) || one !== 1'b1) begin errors++; $display("FAIL rnd_timing d%0d n%0d: got lat=%0d pulse=%b want %0d/1", d, n, lat, one, wlat(d)); end
        checks++; if (er !== exp_err) begin errors++; $display("FAIL rnd_err d%0d n%0d a=%h s=%h: got %b want %b", d, n, a, s, er, exp_err); end
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata d%0d n%0d a=%h s=%h we=%b: got %h want %h", d, n, a, s, w, rd, exp_rd); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; wev[d] = 1'b0; ad[d] = '0; sl[d] = '0; wdt[d] = '0;
    end
    #2;
    test_reset();
    test_rw();
    test_lanes();
    test_range();
    test_held();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
